scan_ctrl: RTL and testbench
============================

# scan_ctrl

Frame sequencer for the tactile sensing matrix. It gates the slot pulse generator, aligns to its switch/read pulses and walks the (switch wire, read wire) indices. For each slot it fires one ADC conversion and emits the sample on a valid/ready stream tagged with row, column and frame markers. It sits between the pulse generator, the wire mux/driver selects, the ADC front end and the downstream frame buffer.

## Interface
- SW_WIRE_CNT, 16, number of switch (drive) wires; rows
- RD_WIRE_CNT, 16, number of read (sense) wires; columns
- ADC_W, 12, ADC sample width
- SW_W = max(1, $clog2(SW_WIRE_CNT)), RD_W = max(1, $clog2(RD_WIRE_CNT)) (derived, not overridable)

Ports:
- clk_ref  in  1  sole clock; everything on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin scan (sampled in IDLE only)
- continuous  in  1  latched at accepted start; 1 = repeat frames
- stop  in  1  clears latched continuous; current frame completes
- clear_err  in  1  clears sticky flags
- active_on  out  1  enable to pulse generator
- pulse_sw  in  1  row-boundary pulse from generator
- pulse_rd  in  1  slot-boundary pulse from generator
- sw_sel  out  SW_W  current switch wire
- rd_sel  out  RD_W  current read wire
- adc_start  out  1  one-cycle conversion request
- adc_done  in  1  one-cycle conversion complete, adc_data valid
- adc_data  in  ADC_W  conversion result
- out_data  out  ADC_W, out_row out SW_W, out_col out RD_W  sample payload
- out_sof / out_eof  out  1  first (0,0) / last (SW-1,RD-1) sample of frame
- out_valid  out  1; out_ready  in  1  stream handshake
- busy  out  1  state != IDLE
- overrun  out  1  sticky: slot pulse arrived before previous slot finished
- sync_err  out  1  sticky: pulse_sw inconsistent with index position

## Operation
- Reset: state IDLE; all outputs 0; indices 0; pending and mode latches cleared.
- IDLE: active_on=0. start=1 -> ARM, latch continuous into mode_cont, sw/rd idx=0. start in any other state is ignored.
- ARM: active_on=1. Waits for a cycle with pulse_rd && pulse_sw, which is a row boundary. Then it goes to CONV for slot (0,0). A lone pulse_rd in ARM is ignored.
- CONV: adc_start=1 on the first CONV cycle only. Waits for adc_done, then latches adc_data, row, col, sof, eof into the out regs, sets out_valid -> OUT.
- OUT: holds payload stable while out_valid && !out_ready. On handshake:
  - if (sw,rd) is the last slot and mode_cont=0 -> IDLE (active_on=0 next cycle);
  - else if pending=1 -> ADVANCE;
  - else -> WAIT.
- WAIT: next pulse_rd -> ADVANCE.
- ADVANCE (one cycle):
  - rd_idx++; at RD_WIRE_CNT-1 it wraps to 0 and sw_idx++.
  - sw_idx wraps from SW_WIRE_CNT-1 to 0, which starts a new frame.
  - clears pending, then -> CONV.
- Last slot with mode_cont=1: the pulse_rd after handshake advances to (0,0) and produces a new frame with sof.
- stop clears mode_cont in any state. The frame in progress still finishes, then the block goes to IDLE.
- Overrun: pulse_rd in CONV or OUT sets overrun and pending. The slot is deferred, not dropped. Further pulses while pending=1 set overrun again and are lost.
- Sync check: each consumed pulse_rd (WAIT, or pending record) requires pulse_sw == (rd_idx == RD_WIRE_CNT-1). A mismatch sets sync_err. A pulse_sw without pulse_rd, outside IDLE/ARM, also sets sync_err. Sync errors never alter sequencing.
- clear_err clears both sticky flags; a same-cycle set event wins.
- adc_done outside CONV is ignored. Mid-operation rst returns to IDLE and drops out_valid and active_on on the next edge.

## Timing
- start at cycle t -> busy, active_on =1 at t+1.
- Aligned pulse at cycle p in ARM -> adc_start=1 at p+1, sw_sel=rd_sel=0.
- pulse_rd at w in WAIT -> ADVANCE at w+1. New sw_sel/rd_sel and adc_start=1 both at w+2. sw_sel/rd_sel change only on ADVANCE.
- adc_done at d -> out_valid=1 at d+1. Minimum done-to-valid latency is 1.
- Handshake at h: out_valid=0 at h+1. With pending set, ADVANCE at h+1 and adc_start at h+2.
- Slot budget: a slot is sustained without overrun if the ADC latency plus the ready stall plus 3 cycles is less than the pulse_rd period.

## Test plan
- SW=2, RD=3, single frame, adc_done 2 cycles after adc_start, out_ready=1:
  - 6 samples, (row,col) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2);
  - sof only on the first sample, eof only on the last;
  - active_on falls the cycle after the last handshake; no flags set.
- Continuous mode, 2 frames, then stop mid-frame 2: frame 2 completes with eof, then IDLE; second sof at (0,0).
- Hold out_ready=0 across one pulse_rd: overrun=1; the deferred slot is still produced with the next index; clear_err clears overrun to 0.
- Inject pulse_sw with a pulse_rd at rd_idx=0: sync_err=1; the sample sequence is unchanged.
- rst asserted while in OUT with out_valid=1: next cycle all outputs 0 and state IDLE; a fresh start re-aligns to (0,0).
- start while busy, and adc_done while in WAIT: both ignored; no extra samples, indices unchanged.

Source files
------------

// File: rtl/scan_ctrl.sv
// scan_ctrl: frame sequencer for the tactile sensing matrix.
// Gates the slot pulse generator, walks (switch, read) wire indices, fires one
// ADC conversion per slot and streams tagged samples over valid/ready.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | pulse generator off, waiting for start
// ARM     | generator on, waiting for an aligned pulse_rd && pulse_sw
// CONV    | conversion requested, waiting for adc_done
// OUT     | sample presented, waiting for out_ready
// WAIT    | slot finished early, waiting for the next pulse_rd
// ADVANCE | step to the next slot (one cycle), then convert again
module scan_ctrl #(
    parameter int SW_WIRE_CNT = 16,
    parameter int RD_WIRE_CNT = 16,
    parameter int ADC_W       = 12,
    localparam int SW_W = ($clog2(SW_WIRE_CNT) < 1) ? 1 : $clog2(SW_WIRE_CNT),
    localparam int RD_W = ($clog2(RD_WIRE_CNT) < 1) ? 1 : $clog2(RD_WIRE_CNT)
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    input  logic             stop,
    input  logic             clear_err,
    output logic             active_on,
    input  logic             pulse_sw,
    input  logic             pulse_rd,
    output logic [SW_W-1:0]  sw_sel,
    output logic [RD_W-1:0]  rd_sel,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] out_data,
    output logic [SW_W-1:0]  out_row,
    output logic [RD_W-1:0]  out_col,
    output logic             out_sof,
    output logic             out_eof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             sync_err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_OUT  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_ADV  = 3'd5;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [SW_W-1:0]  r_sw_idx;
    logic [RD_W-1:0]  r_rd_idx;
    logic             r_mode_cont;
    logic             r_pending;
    logic             r_adc_start;
    logic [ADC_W-1:0] r_out_data;
    logic [SW_W-1:0]  r_out_row;
    logic [RD_W-1:0]  r_out_col;
    logic             r_out_sof;
    logic             r_out_eof;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_sync_err;

    logic w_last_rd;
    logic w_last_sw;
    logic w_last;
    logic w_hs;
    logic w_rd_defer;
    logic w_rd_consume;
    logic w_sync_set;

    assign w_last_rd  = (r_rd_idx == RD_W'(RD_WIRE_CNT - 1));
    assign w_last_sw  = (r_sw_idx == SW_W'(SW_WIRE_CNT - 1));
    assign w_last     = w_last_rd && w_last_sw;
    assign w_hs       = r_out_valid && out_ready;
    // A slot pulse while the previous slot is still busy is remembered, not dropped.
    assign w_rd_defer = pulse_rd && ((r_state == S_CONV) || (r_state == S_OUT));
    // Only a pulse that will actually start the next slot is checked against the row position.
    assign w_rd_consume = (pulse_rd && (r_state == S_WAIT)) || (w_rd_defer && !r_pending);
    assign w_sync_set = (w_rd_consume && (pulse_sw != w_last_rd)) ||
                        (pulse_sw && !pulse_rd && (r_state != S_IDLE) && (r_state != S_ARM));

    // Next-state selection for the slot sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_ARM;
            S_ARM:  if (pulse_rd && pulse_sw) w_state_nxt = S_CONV;
            S_CONV: if (adc_done) w_state_nxt = S_OUT;
            S_OUT: begin
                if (w_hs) begin
                    if (w_last && !r_mode_cont)     w_state_nxt = S_IDLE;
                    else if (r_pending || pulse_rd) w_state_nxt = S_ADV;
                    else                            w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: if (pulse_rd) w_state_nxt = S_ADV;
            S_ADV:  w_state_nxt = S_CONV;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, slot indices, mode/pending latches and the output sample register.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sw_idx    <= '0;
            r_rd_idx    <= '0;
            r_mode_cont <= 1'b0;
            r_pending   <= 1'b0;
            r_adc_start <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_adc_start <= 1'b0;
            if (stop)
                r_mode_cont <= 1'b0;
            else if ((r_state == S_IDLE) && start)
                r_mode_cont <= continuous;
            if (w_rd_defer)
                r_pending <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sw_idx  <= '0;
                        r_rd_idx  <= '0;
                        r_pending <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (pulse_rd && pulse_sw)
                        r_adc_start <= 1'b1;
                end
                S_CONV: begin
                    if (adc_done) begin
                        r_out_data  <= adc_data;
                        r_out_row   <= r_sw_idx;
                        r_out_col   <= r_rd_idx;
                        r_out_sof   <= (r_sw_idx == '0) && (r_rd_idx == '0);
                        r_out_eof   <= w_last;
                        r_out_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_hs) begin
                        r_out_valid <= 1'b0;
                        // A pulse beyond the final slot of the last frame belongs to nobody.
                        if (w_last && !r_mode_cont)
                            r_pending <= 1'b0;
                    end
                end
                S_ADV: begin
                    r_pending   <= 1'b0;
                    r_adc_start <= 1'b1;
                    if (w_last_rd) begin
                        r_rd_idx <= '0;
                        r_sw_idx <= w_last_sw ? '0 : r_sw_idx + SW_W'(1);
                    end else begin
                        r_rd_idx <= r_rd_idx + RD_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Sticky error flags; a set event in the same cycle as clear_err wins.
    always_ff @(posedge clk_ref) begin
        if (rst) begin
            r_overrun  <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_overrun  <= w_rd_defer | (r_overrun & ~clear_err);
            r_sync_err <= w_sync_set | (r_sync_err & ~clear_err);
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign active_on = busy;
    assign sw_sel    = r_sw_idx;
    assign rd_sel    = r_rd_idx;
    assign adc_start = r_adc_start;
    assign out_data  = r_out_data;
    assign out_row   = r_out_row;
    assign out_col   = r_out_col;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed scenarios with randomized pulse period, ADC latency
// and ADC data; samples are compared against a frame-order model.
module tb_scan_ctrl;

    localparam int SW  = 2;
    localparam int RD  = 3;
    localparam int AW  = 12;
    localparam int SWW = 1;
    localparam int RDW = 2;

    logic           clk_ref = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           continuous = 1'b0;
    logic           stop = 1'b0;
    logic           clear_err = 1'b0;
    logic           active_on;
    logic           pulse_sw = 1'b0;
    logic           pulse_rd = 1'b0;
    logic [SWW-1:0] sw_sel;
    logic [RDW-1:0] rd_sel;
    logic           adc_start;
    logic           adc_done;
    logic [AW-1:0]  adc_data = '0;
    logic [AW-1:0]  out_data;
    logic [SWW-1:0] out_row;
    logic [RDW-1:0] out_col;
    logic           out_sof;
    logic           out_eof;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           busy;
    logic           overrun;
    logic           sync_err;

    logic resp_done = 1'b0;
    logic spur_done = 1'b0;
    assign adc_done = resp_done | spur_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int period = 12;
    bit inject_en = 1'b0;
    int last_hs_cyc = 0;
    int idle_cyc = 0;
    int base_got = 0;
    int base_adc = 0;
    int base_conv = 0;
    int base_p0 = 0;

    logic [31:0]   got_q[$];
    logic [AW-1:0] adc_q[$];
    int            conv_q[$];
    int            p0_q[$];

    scan_ctrl #(.SW_WIRE_CNT(SW), .RD_WIRE_CNT(RD), .ADC_W(AW)) dut (
        .clk_ref(clk_ref), .rst(rst), .start(start), .continuous(continuous),
        .stop(stop), .clear_err(clear_err), .active_on(active_on),
        .pulse_sw(pulse_sw), .pulse_rd(pulse_rd), .sw_sel(sw_sel), .rd_sel(rd_sel),
        .adc_start(adc_start), .adc_done(adc_done), .adc_data(adc_data),
        .out_data(out_data), .out_row(out_row), .out_col(out_col),
        .out_sof(out_sof), .out_eof(out_eof), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun), .sync_err(sync_err)
    );

    always #5 clk_ref = ~clk_ref;

    always @(posedge clk_ref) cyc++;

    function automatic logic [31:0] pack(int row, int col, bit sof, bit eof, int data);
        return 32'((row << 24) | (col << 16) | (int'(sof) << 15) | (int'(eof) << 14) | (data & 'hFFF));
    endfunction

    // Frame order model: sample i of a run is slot i mod (SW*RD), row-major.
    function automatic logic [31:0] exp_word(int i);
        int k;
        k = i % (SW * RD);
        return pack(k / RD, k % RD, k == 0, k == SW * RD - 1, int'(adc_q[base_adc + i]));
    endfunction

    // Slot pulse generator: one pulse_rd per period, pulse_sw on every row start.
    int gcnt = 0;
    int gk = 0;
    always @(posedge clk_ref) begin
        #1;
        pulse_rd = 1'b0;
        pulse_sw = 1'b0;
        if (rst || !active_on) begin
            gcnt = 0;
            gk = 0;
        end else begin
            gcnt++;
            if (gcnt % period == 3) begin
                pulse_rd = 1'b1;
                pulse_sw = ((gk % RD) == 0) || (inject_en && gk == 1);
                if (gk == 0) p0_q.push_back(cyc);
                gk++;
            end
        end
    end

    // ADC front end: random 1..3 cycle latency, random data.
    int cd = 0;
    always @(posedge clk_ref) begin
        #1;
        resp_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    resp_done = 1'b1;
                    adc_data = AW'($urandom);
                    adc_q.push_back(adc_data);
                end
            end
            if (adc_start) begin
                cd = $urandom_range(1, 3);
                conv_q.push_back(cyc);
            end
        end
    end

    // Stream sink monitor.
    always @(negedge clk_ref) begin
        if (!rst && out_valid && out_ready) begin
            got_q.push_back(pack(int'(out_row), int'(out_col), out_sof, out_eof, int'(out_data)));
            last_hs_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic new_run();
        base_got  = got_q.size();
        base_adc  = adc_q.size();
        base_conv = conv_q.size();
        base_p0   = p0_q.size();
        period    = $urandom_range(10, 14);
    endtask

    task automatic start_scan(input bit cont);
        tick();
        start = 1'b1;
        continuous = cont;
        tick();
        start = 1'b0;
        continuous = 1'b0;
        @(negedge clk_ref);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (busy && n < budget);
        chk({tag, " idle timeout"}, busy, 0);
        idle_cyc = cyc;
    endtask

    task automatic wait_count(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while ((got_q.size() - base_got) < cnt && n < budget) begin
            @(negedge clk_ref);
            n++;
        end
        chk({tag, " sample wait"}, (got_q.size() - base_got) >= cnt, 1);
    endtask

    task automatic check_seq(input string tag, input int n);
        chk({tag, " count"}, got_q.size() - base_got, n);
        for (int i = 0; i < n && (base_got + i) < got_q.size() && (base_adc + i) < adc_q.size(); i++)
            chk($sformatf("%s sample%0d", tag, i), got_q[base_got + i], exp_word(i));
    endtask

    task automatic pulse_clear();
        tick();
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        @(negedge clk_ref);
    endtask

    initial begin
        int n;
        int sofs;

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk_ref);
        chk("reset ctrl", {busy, active_on, adc_start, out_valid, out_sof, out_eof, overrun, sync_err}, 0);
        chk("reset sel", {sw_sel, rd_sel}, 0);
        chk("reset payload", {out_data, out_row, out_col}, 0);

        // Single frames with random period/latency/data.
        for (int r = 0; r < 3; r++) begin
            new_run();
            start_scan(1'b0);
            chk("t1 busy active_on", {busy, active_on}, 2'b11);
            wait_idle("t1", 3000);
            check_seq("t1", SW * RD);
            chk("t1 active_on fall", idle_cyc, last_hs_cyc + 1);
            if (conv_q.size() > base_conv && p0_q.size() > base_p0)
                chk("t1 first adc_start", conv_q[base_conv], p0_q[base_p0] + 1);
            else
                chk("t1 first adc_start missing", 0, 1);
            chk("t1 flags", {overrun, sync_err}, 0);
        end

        // Continuous frames, stop in the middle of frame 2.
        new_run();
        start_scan(1'b1);
        wait_count("t2 mid", SW * RD + 2, 3000);
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("t2", 3000);
        check_seq("t2", 2 * SW * RD);
        sofs = 0;
        for (int i = base_got; i < got_q.size(); i++) sofs += int'(got_q[i][15]);
        chk("t2 sof count", sofs, 2);
        chk("t2 flags", {overrun, sync_err}, 0);

        // Stall out_ready across one slot pulse.
        new_run();
        start_scan(1'b0);
        wait_count("t3 first", 1, 3000);
        tick();
        out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (!(out_valid && pulse_rd) && n < 200);
        chk("t3 pulse during OUT", out_valid && pulse_rd, 1);
        tick();
        chk("t3 overrun set", overrun, 1);
        out_ready = 1'b1;
        wait_idle("t3", 3000);
        check_seq("t3", SW * RD);
        chk("t3 flags after frame", {overrun, sync_err}, 2'b10);
        pulse_clear();
        chk("t3 overrun cleared", overrun, 0);

        // Stray pulse_sw on a mid-row slot.
        new_run();
        inject_en = 1'b1;
        start_scan(1'b0);
        wait_idle("t4", 3000);
        inject_en = 1'b0;
        check_seq("t4", SW * RD);
        chk("t4 flags", {overrun, sync_err}, 2'b01);
        pulse_clear();
        chk("t4 sync_err cleared", sync_err, 0);

        // Reset while a sample is held in OUT.
        new_run();
        start_scan(1'b0);
        wait_count("t5 pre", 2, 3000);
        tick();
        out_ready = 1'b0;
        n = 0;
        do begin
            @(negedge clk_ref);
            n++;
        end while (!out_valid && n < 200);
        chk("t5 valid held", out_valid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk_ref);
        chk("t5 rst ctrl", {busy, active_on, adc_start, out_valid, out_sof, out_eof, overrun, sync_err}, 0);
        chk("t5 rst sel", {sw_sel, rd_sel}, 0);
        chk("t5 rst payload", {out_data, out_row, out_col}, 0);
        out_ready = 1'b1;
        new_run();
        start_scan(1'b0);
        wait_idle("t5", 3000);
        check_seq("t5", SW * RD);

        // Spurious adc_done in WAIT and start while busy.
        new_run();
        start_scan(1'b0);
        wait_count("t6 a", 2, 3000);
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        @(negedge clk_ref);
        chk("t6 after stray done", {busy, out_valid, adc_start, sw_sel, rd_sel}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd1});
        wait_count("t6 b", 3, 3000);
        tick();
        start = 1'b1;
        continuous = 1'b1;
        tick();
        start = 1'b0;
        continuous = 1'b0;
        wait_idle("t6", 3000);
        check_seq("t6", SW * RD);
        chk("t6 flags", {overrun, sync_err}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
